tpl_adc_pn_monitor: RTL and testbench
=====================================

TPL_ADC_PN_MONITOR -- requirements
Module: tpl_adc_pn_monitor

Interface
REQ-001 SHALL have parameter SAMPLES_PER_BEAT, default 2: converter samples per beat.
REQ-002 SHALL have parameter SAMPLE_WIDTH, default 16: bits per sample; beat width DW = SAMPLES_PER_BEAT*SAMPLE_WIDTH.
REQ-003 SHALL have parameter OOS_THRESHOLD, default 16: consecutive-event count for sync entry and exit; legal range 2..255.
REQ-004 SHALL have port link_clk, input, 1: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port adc_rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port data, input, DW: one channel's deframed beat; sample 0 in the LSBs and oldest in time.
REQ-007 SHALL have port data_valid, input, 1: qualifies data; beats with data_valid low are ignored entirely.
REQ-008 SHALL have port pn_seq_sel, input, 4: sequence select; 0 = PN9, 1 = PN23, any other value = monitor disabled.
REQ-009 SHALL have port pn_err, output, 1: one-cycle pulse per mismatched beat while in sync.
REQ-010 SHALL have port pn_oos, output, 1: level, high while out of sync.

Function
REQ-011 SHALL implement the PN9 polynomial as x^9+x^5+1 and the PN23 polynomial as x^23+x^18+1, each advanced DW bits per beat, MSB-first per sample.
REQ-012 SHALL compute expected(t) = next_beat(ref(t-1)), where ref is the last valid received beat in OOS state and the last expected beat in SYNC state.
REQ-013 SHALL define match(t) = (data == expected) AND (data != 0); an all-zero beat never matches.
REQ-014 SHALL implement two states, OOS and SYNC, plus an 8-bit event counter cnt.
REQ-015 SHALL, in OOS, increment cnt on a valid match and clear it on a valid mismatch; a match when cnt == OOS_THRESHOLD-1 SHALL move to SYNC with cnt = 0.
REQ-016 SHALL, in SYNC, increment cnt on a valid mismatch and clear it on a valid match; a mismatch when cnt == OOS_THRESHOLD-1 SHALL move to OOS with cnt = 0.
REQ-017 SHALL treat the first valid beat after reset, after a select change, or on entry to OOS as a seed only: no match is evaluated for it.
REQ-018 SHALL assert pn_err for exactly one cycle for each valid beat that mismatches in SYNC, including the beat that causes the transition to OOS.
REQ-019 SHALL have a latency of 2 cycles (input register, then result register) from a beat sampled at the input to the corresponding pn_err/pn_oos update.
REQ-020 SHALL, on any change of pn_seq_sel, force OOS, clear cnt, and re-seed on the next valid beat; a beat arriving in the same cycle as the change is a seed.
REQ-021 SHALL, while disabled, hold pn_oos = 1 and pn_err = 0.
REQ-022 SHALL hold state, cnt, and outputs unchanged when data_valid is low; gaps SHALL NOT break match runs.

Reset
REQ-023 SHALL, on adc_rst, set pn_oos = 1, pn_err = 0, state = OOS, cnt = 0, ref = 0, and clear the seed flag and pipeline valids.
REQ-024 SHALL make adc_rst asserted mid-run override all other events in that cycle; beats in flight are discarded.

Structure
REQ-025 SHALL place the polynomial tap constants, the PN_SEL_PN9/PN_SEL_PN23 codes, and the state encoding in shared package tpl_adc_pn_pkg.
REQ-026 SHALL implement the DW-bit LFSR advance as combinational sub-module tpl_pn_gen (parameters DW and sequence select; ports ref and next), instantiated once with a select mux.

Verification
REQ-027 SHALL verify that PN9 with defaults, seed beat 0x1FF-derived, and 17 consecutive correct beats deasserts pn_oos 2 cycles after beat 17, with pn_err never asserted.
REQ-028 SHALL verify that, in SYNC, one corrupted beat (bit 0 flipped) then correct beats gives a single 1-cycle pn_err, pn_oos stays 0, and cnt returns to 0.
REQ-029 SHALL verify that, in SYNC, 16 consecutive beats of 0x0000_0000 give 16 pn_err pulses and pn_oos rising 2 cycles after beat 16.
REQ-030 SHALL verify that PN23 in sync, with pn_seq_sel switched to 1 then 0 while PN23 data continues, gives pn_oos = 1 within 2 cycles that never clears.
REQ-031 SHALL verify that PN9 with data_valid toggled 1-0-1 every cycle over 17 valid beats still reaches sync, and that pn_seq_sel = 5 holds pn_oos = 1 and pn_err = 0.
REQ-032 SHALL verify that adc_rst asserted for 1 cycle during SYNC gives pn_oos = 1 the next cycle, and that 17 further correct beats are needed to resync.

Source files
------------

// File: rtl/tpl_adc_pn_pkg.sv
// Shared constants for the ADC PN monitor: sequence select codes, LFSR tap
// positions, monitor state encoding, and the beat bit-ordering helper.
package tpl_adc_pn_pkg;

  // pn_seq_sel codes; any other value disables the monitor.
  localparam logic [3:0] PN_SEL_PN9  = 4'd0;
  localparam logic [3:0] PN_SEL_PN23 = 4'd1;

  // Tap positions: bit b[n] = b[n-LEN] ^ b[n-TAP] of the serial stream.
  // PN9  : x^9  + x^5  + 1
  // PN23 : x^23 + x^18 + 1
  localparam int PN9_LEN  = 9;
  localparam int PN9_TAP  = 5;
  localparam int PN23_LEN = 23;
  localparam int PN23_TAP = 18;

  // Monitor state encoding.
  localparam logic [0:0] ST_OOS  = 1'b0;
  localparam logic [0:0] ST_SYNC = 1'b1;

  // Lock-tracking state, kept in one struct so it can be probed as a unit.
  typedef struct packed {
    logic [0:0] state;   // ST_OOS / ST_SYNC
    logic [7:0] cnt;     // consecutive match (OOS) or mismatch (SYNC) count
    logic       seeded;  // a reference beat has been captured
  } pn_mon_t;

  // Maps serial stream position (0 = oldest bit of the beat) to the bit
  // index inside the beat: sample 0 in the LSBs, each sample MSB-first.
  function automatic int pn_beat_bit(input int pos, input int sw);
    return (pos / sw) * sw + (sw - 1 - (pos % sw));
  endfunction

  function automatic logic pn_sel_enabled(input logic [3:0] sel);
    return (sel == PN_SEL_PN9) || (sel == PN_SEL_PN23);
  endfunction

endpackage

// File: rtl/tpl_pn_gen.sv
// Combinational DW-bit advance of the PN9/PN23 stream. The last LEN stream
// bits of ref_beat form the LFSR state; next_beat holds the following DW
// stream bits. Beat width must be at least 23 bits so PN23 history fits.
module tpl_pn_gen
  import tpl_adc_pn_pkg::*;
#(
  parameter int DW           = 32,
  parameter int SAMPLE_WIDTH = 16
) (
  input  logic [3:0]    seq_sel,
  input  logic [DW-1:0] ref_beat,
  output logic [DW-1:0] next_beat
);

  localparam int IW = (DW > 1) ? $clog2(DW) : 1;

  // Load history from the tail of the reference beat, then run the
  // recurrence DW times; hist[0] is always the newest stream bit.
  always_comb begin
    logic [PN23_LEN-1:0] hist;
    logic                nb;
    hist      = '0;
    nb        = 1'b0;
    next_beat = '0;
    for (int k = 0; k < PN23_LEN; k++) begin
      if (k < DW) begin
        hist[k] = ref_beat[IW'(pn_beat_bit(DW - 1 - k, SAMPLE_WIDTH))];
      end
    end
    for (int i = 0; i < DW; i++) begin
      if (seq_sel == PN_SEL_PN23) begin
        nb = hist[PN23_LEN-1] ^ hist[PN23_TAP-1];
      end else begin
        nb = hist[PN9_LEN-1] ^ hist[PN9_TAP-1];
      end
      hist = {hist[PN23_LEN-2:0], nb};
      next_beat[IW'(pn_beat_bit(i, SAMPLE_WIDTH))] = nb;
    end
  end

endmodule

// File: rtl/tpl_adc_pn_monitor.sv
// PN9/PN23 sequence monitor for one deframed ADC channel.
// Stage 1 registers the incoming beat; stage 2 compares it with the
// predicted beat and updates the OOS/SYNC tracker and the outputs.
// data_valid is a pure qualifier (no backpressure): a beat is consumed in
// every cycle where data_valid is high, and cycles with it low are ignored.
module tpl_adc_pn_monitor
  import tpl_adc_pn_pkg::*;
#(
  parameter int SAMPLES_PER_BEAT = 2,
  parameter int SAMPLE_WIDTH     = 16,
  parameter int OOS_THRESHOLD    = 16
) (
  input  logic                                   link_clk,
  input  logic                                   adc_rst,
  input  logic [SAMPLES_PER_BEAT*SAMPLE_WIDTH-1:0] data,
  input  logic                                   data_valid,
  input  logic [3:0]                             pn_seq_sel,
  output logic                                   pn_err,
  output logic                                   pn_oos
);

  localparam int         DW       = SAMPLES_PER_BEAT * SAMPLE_WIDTH;
  localparam logic [7:0] CNT_LAST = 8'(OOS_THRESHOLD - 1);

  // Stage 1: input register.
  logic [DW-1:0] data_s1_q, data_s1_d;
  logic          valid_s1_q, valid_s1_d;
  logic [3:0]    sel_s1_q, sel_s1_d;

  // Stage 2: tracker and result register.
  pn_mon_t       mon_q, mon_d;
  logic [DW-1:0] ref_q, ref_d;
  logic [3:0]    sel_cur_q, sel_cur_d;
  logic          pn_err_q, pn_err_d;
  logic          pn_oos_q, pn_oos_d;

  logic [DW-1:0] expected;
  logic          match;

  tpl_pn_gen #(
    .DW           (DW),
    .SAMPLE_WIDTH (SAMPLE_WIDTH)
  ) u_pn_gen (
    .seq_sel   (sel_cur_q),
    .ref_beat  (ref_q),
    .next_beat (expected)
  );

  // All-zero beats never match so a dead link cannot look locked.
  assign match = (data_s1_q == expected) && (data_s1_q != '0);

  // Stage 1 next-state: capture the raw input every cycle.
  always_comb begin
    data_s1_d  = data;
    valid_s1_d = data_valid;
    sel_s1_d   = pn_seq_sel;
  end

  // Stage 2 next-state: seed handling, select changes, OOS/SYNC tracking.
  always_comb begin
    mon_d     = mon_q;
    ref_d     = ref_q;
    sel_cur_d = sel_s1_q;
    pn_err_d  = 1'b0;
    pn_oos_d  = pn_oos_q;

    if ((sel_s1_q != sel_cur_q) || !pn_sel_enabled(sel_s1_q)) begin
      // Select change or disabled: drop lock; a beat riding with the
      // change becomes the new seed.
      mon_d.state  = ST_OOS;
      mon_d.cnt    = '0;
      mon_d.seeded = 1'b0;
      if (pn_sel_enabled(sel_s1_q) && valid_s1_q) begin
        ref_d        = data_s1_q;
        mon_d.seeded = 1'b1;
      end
    end else if (valid_s1_q) begin
      if (!mon_q.seeded) begin
        ref_d        = data_s1_q;
        mon_d.seeded = 1'b1;
      end else if (mon_q.state == ST_OOS) begin
        // Acquisition: follow the received data.
        ref_d = data_s1_q;
        if (match) begin
          if (mon_q.cnt == CNT_LAST) begin
            mon_d.state = ST_SYNC;
            mon_d.cnt   = '0;
          end else begin
            mon_d.cnt = mon_q.cnt + 8'd1;
          end
        end else begin
          mon_d.cnt = '0;
        end
      end else begin
        // Locked: free-run the local sequence so bad beats do not corrupt it.
        ref_d = expected;
        if (match) begin
          mon_d.cnt = '0;
        end else begin
          pn_err_d = 1'b1;
          if (mon_q.cnt == CNT_LAST) begin
            mon_d.state  = ST_OOS;
            mon_d.cnt    = '0;
            mon_d.seeded = 1'b0;
          end else begin
            mon_d.cnt = mon_q.cnt + 8'd1;
          end
        end
      end
    end

    pn_oos_d = (mon_d.state == ST_OOS);
  end

  // Stage 1 register.
  always_ff @(posedge link_clk) begin
    if (adc_rst) begin
      data_s1_q  <= '0;
      valid_s1_q <= 1'b0;
      sel_s1_q   <= PN_SEL_PN9;
    end else begin
      data_s1_q  <= data_s1_d;
      valid_s1_q <= valid_s1_d;
      sel_s1_q   <= sel_s1_d;
    end
  end

  // Stage 2 register.
  always_ff @(posedge link_clk) begin
    if (adc_rst) begin
      mon_q     <= '{state: ST_OOS, cnt: 8'd0, seeded: 1'b0};
      ref_q     <= '0;
      sel_cur_q <= PN_SEL_PN9;
      pn_err_q  <= 1'b0;
      pn_oos_q  <= 1'b1;
    end else begin
      mon_q     <= mon_d;
      ref_q     <= ref_d;
      sel_cur_q <= sel_cur_d;
      pn_err_q  <= pn_err_d;
      pn_oos_q  <= pn_oos_d;
    end
  end

  assign pn_err = pn_err_q;
  assign pn_oos = pn_oos_q;

endmodule

// File: tb/tb_tpl_adc_pn_monitor.sv
// Directed bench for tpl_adc_pn_monitor with default parameters.
module tb_tpl_adc_pn_monitor;

  logic        link_clk;
  logic        adc_rst;
  logic [31:0] data;
  logic        data_valid;
  logic [3:0]  pn_seq_sel;
  logic        pn_err;
  logic        pn_oos;

  int total;
  int bad;

  // Expected {err, oos} per driven cycle; checked two cycles later.
  logic [1:0] exp_q[$];
  string      tag_q[$];

  logic [3:0]  cur_sel;
  logic [22:0] sh;      // serial reference stream history, sh[0] newest
  logic        gen23;
  logic [31:0] beat;

  tpl_adc_pn_monitor dut (
    .link_clk   (link_clk),
    .adc_rst    (adc_rst),
    .data       (data),
    .data_valid (data_valid),
    .pn_seq_sel (pn_seq_sel),
    .pn_err     (pn_err),
    .pn_oos     (pn_oos)
  );

  // Clock.
  initial link_clk = 1'b0;
  always #5 link_clk = ~link_clk;

  task automatic check_bit(input string tag, input logic obs, input logic expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  task automatic gen_init(input logic is23);
    sh    = '1;
    gen23 = is23;
  endtask

  // Bit-serial reference generator, packed sample 0 low, MSB-first.
  task automatic gen_beat(output logic [31:0] b);
    logic nb;
    b = '0;
    for (int i = 0; i < 32; i++) begin
      nb = gen23 ? (sh[22] ^ sh[17]) : (sh[8] ^ sh[4]);
      sh = {sh[21:0], nb};
      b[(i / 16) * 16 + 15 - (i % 16)] = nb;
    end
  endtask

  task automatic cyc(input logic [31:0] d, input logic v, input logic e_err,
                     input logic e_oos, input string tag);
    logic [1:0] e;
    string      t;
    @(negedge link_clk);
    if (exp_q.size() == 2) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check_bit({t, ".err"}, pn_err, e[1]);
      check_bit({t, ".oos"}, pn_oos, e[0]);
    end
    data       = d;
    data_valid = v;
    pn_seq_sel = cur_sel;
    exp_q.push_back({e_err, e_oos});
    tag_q.push_back(tag);
  endtask

  task automatic pn_beat(input logic e_err, input logic e_oos, input string tag);
    logic [31:0] b;
    gen_beat(b);
    cyc(b, 1'b1, e_err, e_oos, tag);
  endtask

  task automatic idle(input logic e_oos, input string tag);
    cyc($urandom, 1'b0, 1'b0, e_oos, tag);
  endtask

  task automatic mid_reset();
    @(negedge link_clk);
    adc_rst    = 1'b1;
    data       = $urandom;
    data_valid = 1'b1;
    @(negedge link_clk);
    adc_rst    = 1'b0;
    data_valid = 1'b0;
    check_bit("mid_rst.oos", pn_oos, 1'b1);
    check_bit("mid_rst.err", pn_err, 1'b0);
    exp_q.delete();
    tag_q.delete();
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    adc_rst    = 1'b1;
    data       = '0;
    data_valid = 1'b0;
    cur_sel    = 4'd0;
    pn_seq_sel = 4'd0;
    gen_init(1'b0);

    // Reset state.
    repeat (3) @(negedge link_clk);
    check_bit("reset.oos", pn_oos, 1'b1);
    check_bit("reset.err", pn_err, 1'b0);
    adc_rst = 1'b0;

    // PN9 acquisition: seed + 16 matches, sync on beat 17.
    gen_init(1'b0);
    for (int k = 1; k <= 17; k++) pn_beat(1'b0, (k < 17), "pn9_acq");

    // Single corrupted beat in sync.
    gen_beat(beat);
    cyc(beat ^ 32'h1, 1'b1, 1'b1, 1'b0, "one_err");
    for (int k = 0; k < 3; k++) pn_beat(1'b0, 1'b0, "recover");
    // 15 bad beats stay in sync only if the counter was cleared.
    for (int k = 0; k < 15; k++) begin
      gen_beat(beat);
      cyc(32'h0, 1'b1, 1'b1, 1'b0, "zero15");
    end
    pn_beat(1'b0, 1'b0, "cnt_cleared");

    // 16 all-zero beats drop lock on the 16th.
    for (int k = 1; k <= 16; k++) begin
      gen_beat(beat);
      cyc(32'h0, 1'b1, 1'b1, (k == 16), "zero16");
    end
    idle(1'b1, "after_oos");
    idle(1'b1, "after_oos");

    // Reacquire with a gap after every valid beat.
    for (int k = 1; k <= 17; k++) begin
      pn_beat(1'b0, (k < 17), "gap_acq");
      idle((k < 17), "gap_idle");
    end
    idle(1'b0, "gap_done");

    // Disabled select: forced OOS, never an error.
    cur_sel = 4'd5;
    for (int k = 0; k < 3; k++) pn_beat(1'b0, 1'b1, "dis");
    for (int k = 0; k < 3; k++) cyc(32'h0, 1'b1, 1'b0, 1'b1, "dis_zero");

    // PN23 acquisition, then switch to PN9 under PN23 data.
    cur_sel = 4'd1;
    gen_init(1'b1);
    for (int k = 1; k <= 17; k++) pn_beat(1'b0, (k < 17), "pn23_acq");
    pn_beat(1'b0, 1'b0, "pn23_sync");
    cur_sel = 4'd0;
    for (int k = 0; k < 20; k++) pn_beat(1'b0, 1'b1, "pn23_as_pn9");

    // PN9 lock, mid-run reset, then a full reacquisition.
    gen_init(1'b0);
    for (int k = 1; k <= 17; k++) pn_beat(1'b0, (k < 17), "pn9_relock");
    idle(1'b0, "pre_rst");
    idle(1'b0, "pre_rst");
    mid_reset();
    for (int k = 1; k <= 17; k++) pn_beat(1'b0, (k < 17), "post_rst");
    idle(1'b0, "final");
    idle(1'b0, "final");
    idle(1'b0, "final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
